// File: rtl/monitor_cmd_ctrl.sv
// Command sequencer for the monitor UART link: turns write/read command frames into
// register-file accesses, with RTS/CTS flow control and timeout / rx-error aborts.
module monitor_cmd_ctrl #(
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_busy,
  input  logic              rx_error,
  output logic              tx_write,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic              uart_rts,
  output logic              uart_cts,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic [2:0]        state,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_id,
  output logic [7:0]        data_size,
  output logic              err_timeout,
  output logic              err_rx,
  output logic [CNT_W-1:0]  cmd_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    SIZE     = 3'd2,
    WR_DATA  = 3'd3,
    RD_FETCH = 3'd4,
    RD_SEND  = 3'd5,
    RD_WAIT  = 3'd6,
    DONE     = 3'd7
  } state_e;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [7:0]        index_q;
  logic [TW-1:0]     timer_q;
  logic              counting;
  logic              rxAbort;
  logic              timeoutHit;
  logic [ADDR_W-1:0] accessAddr;

  assign state      = state_q;
  assign accessAddr = cmd_id + ADDR_W'(index_q);
  assign counting   = (state_q != IDLE) && (state_q != DONE);
  assign rxAbort    = rx_error && ((state_q == CMD) || (state_q == SIZE) || (state_q == WR_DATA));
  // A byte or frame completion on the last count cycle counts as progress and beats the timeout.
  assign timeoutHit = counting && !rx_valid && !tx_done && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      index_q     <= '0;
      timer_q     <= '0;
      uart_cts    <= 1'b1;
      tx_write    <= 1'b0;
      tx_byte     <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      cmd_rw      <= 1'b0;
      cmd_id      <= '0;
      data_size   <= '0;
      err_timeout <= 1'b0;
      err_rx      <= 1'b0;
      cmd_count   <= '0;
    end else begin
      tx_write    <= 1'b0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      err_timeout <= 1'b0;
      err_rx      <= 1'b0;

      if (!counting || rx_valid || tx_done) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      if (rxAbort) begin
        err_rx   <= 1'b1;
        uart_cts <= 1'b1;
        state_q  <= IDLE;
      end else if (timeoutHit) begin
        err_timeout <= 1'b1;
        uart_cts    <= 1'b1;
        state_q     <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            uart_cts <= 1'b1;
            if (!uart_rts && !rx_busy) begin
              uart_cts <= 1'b0;
              state_q  <= CMD;
            end
          end
          CMD: begin
            if (rx_valid) begin
              cmd_rw  <= rx_byte[7];
              cmd_id  <= ADDR_W'(rx_byte[6:0]);
              state_q <= SIZE;
            end
          end
          SIZE: begin
            if (rx_valid) begin
              data_size <= rx_byte;
              index_q   <= '0;
              if (rx_byte == 8'd0) begin
                uart_cts <= 1'b1;
                state_q  <= DONE;
              end else if (cmd_rw) begin
                state_q <= WR_DATA;
              end else begin
                uart_cts <= 1'b1;
                state_q  <= RD_FETCH;
              end
            end
          end
          WR_DATA: begin
            if (rx_valid) begin
              reg_we    <= 1'b1;
              reg_addr  <= accessAddr;
              reg_wdata <= rx_byte;
              index_q   <= index_q + 8'd1;
              if (index_q == data_size - 8'd1) begin
                uart_cts <= 1'b1;
                state_q  <= DONE;
              end
            end
          end
          RD_FETCH: begin
            if (!tx_busy) begin
              reg_re   <= 1'b1;
              reg_addr <= accessAddr;
              timer_q  <= '0;
              state_q  <= RD_SEND;
            end
          end
          // The read strobe is high during the first RD_SEND cycle; data is captured on the second.
          RD_SEND: begin
            if (!reg_re) begin
              tx_byte  <= reg_rdata;
              tx_write <= 1'b1;
              timer_q  <= '0;
              state_q  <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (tx_done) begin
              index_q <= index_q + 8'd1;
              if (index_q + 8'd1 == data_size) begin
                state_q <= DONE;
              end else begin
                state_q <= RD_FETCH;
              end
            end
          end
          DONE: begin
            cmd_count <= cmd_count + 1'b1;
            uart_cts  <= 1'b1;
            state_q   <= IDLE;
          end
          default: begin
            uart_cts <= 1'b1;
            state_q  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monitor_cmd_ctrl.sv
// Scoreboard bench for monitor_cmd_ctrl: register writes and transmitted bytes are
// queued when commands are sent and popped by a monitor as the DUT produces them.
module tb_monitor_cmd_ctrl;
  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_busy;
  logic              rx_error;
  logic              tx_write;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              tx_done;
  logic              uart_rts;
  logic              uart_cts;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic [2:0]        state;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_id;
  logic [7:0]        data_size;
  logic              err_timeout;
  logic              err_rx;
  logic [CNT_W-1:0]  cmd_count;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        expWrQ[$];
  logic [7:0] expTxQ[$];
  wr_t        wrExp;
  logic [7:0] txExp;
  logic [7:0] mem [0:127];

  int checkCount = 0;
  int passCount  = 0;
  int weCount    = 0;
  int reCount    = 0;
  int txCount    = 0;
  int toCount    = 0;
  int rxeCount   = 0;

  always #5 clk = ~clk;

  monitor_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_busy(rx_busy), .rx_error(rx_error),
    .tx_write(tx_write), .tx_byte(tx_byte), .tx_busy(tx_busy), .tx_done(tx_done),
    .uart_rts(uart_rts), .uart_cts(uart_cts),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .state(state), .cmd_rw(cmd_rw), .cmd_id(cmd_id), .data_size(data_size),
    .err_timeout(err_timeout), .err_rx(err_rx), .cmd_count(cmd_count)
  );

  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  // Transmitter model: busy for a few cycles after each tx_write, then a one-cycle tx_done.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_write === 1'b1) begin
        #1 tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (reg_we === 1'b1) begin
        weCount++;
        checkCount++;
        if (expWrQ.size() == 0) begin
          $display("[TB] FAIL write_sb: unexpected write %h@%h, required none", reg_wdata, reg_addr);
        end else begin
          wrExp = expWrQ.pop_front();
          if ({reg_addr, reg_wdata} !== wrExp || reg_re !== 1'b0)
            $display("[TB] FAIL write_sb: got %h@%h re=%b, required %h@%h re=0",
                     reg_wdata, reg_addr, reg_re, wrExp.data, wrExp.addr);
          else passCount++;
        end
      end
      if (reg_re === 1'b1) reCount++;
      if (tx_write === 1'b1) begin
        txCount++;
        checkCount++;
        if (expTxQ.size() == 0) begin
          $display("[TB] FAIL tx_sb: unexpected tx_byte %h, required none", tx_byte);
        end else begin
          txExp = expTxQ.pop_front();
          if (tx_byte !== txExp || tx_busy !== 1'b0)
            $display("[TB] FAIL tx_sb: got %h busy=%b, required %h busy=0", tx_byte, tx_busy, txExp);
          else passCount++;
        end
      end
      if (err_timeout === 1'b1) toCount++;
      if (err_rx === 1'b1) rxeCount++;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic startCmd();
    uart_rts = 1'b0;
    @(negedge clk);
    checkCount++;
    if (state !== 3'd1 || uart_cts !== 1'b0)
      $display("[TB] FAIL start_cmd: state=%0d cts=%b, required state=1 cts=0", state, uart_cts);
    else passCount++;
    uart_rts = 1'b1;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state === s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rx_busy  = 1'b0;
    rx_error = 1'b0;
    uart_rts = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if (state !== 3'd0 || uart_cts !== 1'b1)
      $display("[TB] FAIL reset_state: state=%0d cts=%b, required 0/1", state, uart_cts);
    else passCount++;
    checkCount++;
    if ({tx_write, reg_we, reg_re, err_timeout, err_rx} !== 5'b0)
      $display("[TB] FAIL reset_pulses: got %b, required 00000",
               {tx_write, reg_we, reg_re, err_timeout, err_rx});
    else passCount++;
    checkCount++;
    if ({tx_byte, reg_addr, reg_wdata, cmd_rw, cmd_id, data_size, cmd_count} !== '0)
      $display("[TB] FAIL reset_regs: tx_byte=%h addr=%h wdata=%h rw=%b id=%h size=%h count=%0d, required all 0",
               tx_byte, reg_addr, reg_wdata, cmd_rw, cmd_id, data_size, cmd_count);
    else passCount++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int weBefore = weCount;
    expWrQ.push_back('{addr: 7'h05, data: 8'hAA});
    expWrQ.push_back('{addr: 7'h06, data: 8'hBB});
    expWrQ.push_back('{addr: 7'h07, data: 8'hCC});
    startCmd();
    applyStimulus(8'h85);
    checkCount++;
    if (cmd_rw !== 1'b1 || cmd_id !== 7'h05 || state !== 3'd2)
      $display("[TB] FAIL write_cmd: rw=%b id=%h state=%0d, required 1/05/2", cmd_rw, cmd_id, state);
    else passCount++;
    applyStimulus(8'h03);
    checkCount++;
    if (state !== 3'd3 || data_size !== 8'd3 || uart_cts !== 1'b0)
      $display("[TB] FAIL write_size: state=%0d size=%0d cts=%b, required 3/3/0", state, data_size, uart_cts);
    else passCount++;
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    checkCount++;
    if (state !== 3'd7 || uart_cts !== 1'b1)
      $display("[TB] FAIL write_last: state=%0d cts=%b, required 7/1", state, uart_cts);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (state !== 3'd0 || cmd_count !== 16'd1 || weCount - weBefore != 3 || expWrQ.size() != 0)
      $display("[TB] FAIL write_done: state=%0d count=%0d writes=%0d pending=%0d, required 0/1/3/0",
               state, cmd_count, weCount - weBefore, expWrQ.size());
    else passCount++;
  endtask

  task automatic test_read();
    bit ok;
    int txBefore;
    int reBefore;
    expWrQ.push_back('{addr: 7'h10, data: 8'h12});
    expWrQ.push_back('{addr: 7'h11, data: 8'h34});
    startCmd();
    applyStimulus(8'h90);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    @(negedge clk);
    txBefore = txCount;
    reBefore = reCount;
    expTxQ.push_back(8'h12);
    expTxQ.push_back(8'h34);
    startCmd();
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    checkCount++;
    if (state !== 3'd4 || uart_cts !== 1'b1)
      $display("[TB] FAIL read_size: state=%0d cts=%b, required 4/1", state, uart_cts);
    else passCount++;
    waitState(3'd0, 200, ok);
    checkCount++;
    if (!ok || txCount - txBefore != 2 || reCount - reBefore != 2 || expTxQ.size() != 0 || cmd_count !== 16'd3)
      $display("[TB] FAIL read_done: idle=%0d tx=%0d re=%0d pending=%0d count=%0d, required 1/2/2/0/3",
               ok, txCount - txBefore, reCount - reBefore, expTxQ.size(), cmd_count);
    else passCount++;
  endtask

  task automatic test_zero_wrap();
    int weBefore = weCount;
    uart_rts = 1'b0;
    @(negedge clk);
    applyStimulus(8'h80);
    applyStimulus(8'h00);
    checkCount++;
    if (state !== 3'd7 || uart_cts !== 1'b1)
      $display("[TB] FAIL zero_size: state=%0d cts=%b, required 7/1", state, uart_cts);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (state !== 3'd0 || cmd_count !== 16'd4 || weCount != weBefore)
      $display("[TB] FAIL zero_done: state=%0d count=%0d writes=%0d, required 0/4/0",
               state, cmd_count, weCount - weBefore);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (state !== 3'd1)
      $display("[TB] FAIL rts_held: state=%0d, required 1", state);
    else passCount++;
    uart_rts = 1'b1;
    expWrQ.push_back('{addr: 7'h7F, data: 8'h11});
    expWrQ.push_back('{addr: 7'h00, data: 8'h22});
    applyStimulus(8'hFF);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(negedge clk);
    checkCount++;
    if (state !== 3'd0 || cmd_count !== 16'd5 || weCount - weBefore != 2 || expWrQ.size() != 0)
      $display("[TB] FAIL wrap_done: state=%0d count=%0d writes=%0d pending=%0d, required 0/5/2/0",
               state, cmd_count, weCount - weBefore, expWrQ.size());
    else passCount++;
  endtask

  task automatic test_timeout();
    int n = 0;
    int toBefore = toCount;
    startCmd();
    applyStimulus(8'h85);
    for (int i = 1; i <= TIMEOUT + 5; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        n = i;
        break;
      end
    end
    checkCount++;
    if (n != TIMEOUT)
      $display("[TB] FAIL timeout_latency: fired after %0d cycles, required %0d", n, TIMEOUT);
    else passCount++;
    checkCount++;
    if (state !== 3'd0 || uart_cts !== 1'b1 || cmd_count !== 16'd5)
      $display("[TB] FAIL timeout_abort: state=%0d cts=%b count=%0d, required 0/1/5", state, uart_cts, cmd_count);
    else passCount++;
    repeat (3) @(negedge clk);
    toBefore = toCount;
    startCmd();
    applyStimulus(8'h85);
    repeat (TIMEOUT - 1) @(negedge clk);
    applyStimulus(8'h00);
    checkCount++;
    if (state !== 3'd7 || err_timeout !== 1'b0)
      $display("[TB] FAIL timeout_race: state=%0d err=%b, required 7/0", state, err_timeout);
    else passCount++;
    repeat (3) @(negedge clk);
    checkCount++;
    if (toCount != toBefore || cmd_count !== 16'd6)
      $display("[TB] FAIL timeout_race_done: timeouts=%0d count=%0d, required 0/6", toCount - toBefore, cmd_count);
    else passCount++;
  endtask

  task automatic test_rx_error();
    int weBefore = weCount;
    int rxeBefore = rxeCount;
    expWrQ.push_back('{addr: 7'h05, data: 8'h01});
    startCmd();
    applyStimulus(8'h85);
    applyStimulus(8'h04);
    applyStimulus(8'h01);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    checkCount++;
    if (err_rx !== 1'b1 || state !== 3'd0 || uart_cts !== 1'b1)
      $display("[TB] FAIL rx_error_abort: err=%b state=%0d cts=%b, required 1/0/1", err_rx, state, uart_cts);
    else passCount++;
    repeat (2) @(negedge clk);
    checkCount++;
    if (weCount - weBefore != 1 || rxeCount - rxeBefore != 1 || expWrQ.size() != 0 || cmd_count !== 16'd6)
      $display("[TB] FAIL rx_error_done: writes=%0d errs=%0d pending=%0d count=%0d, required 1/1/0/6",
               weCount - weBefore, rxeCount - rxeBefore, expWrQ.size(), cmd_count);
    else passCount++;
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int txBefore;
    expWrQ.push_back('{addr: 7'h20, data: 8'h5A});
    expWrQ.push_back('{addr: 7'h21, data: 8'h6B});
    startCmd();
    applyStimulus(8'hA0);
    applyStimulus(8'h02);
    applyStimulus(8'h5A);
    applyStimulus(8'h6B);
    @(negedge clk);
    txBefore = txCount;
    expTxQ.push_back(8'h5A);
    startCmd();
    applyStimulus(8'h20);
    applyStimulus(8'h02);
    waitState(3'd6, 100, ok);
    @(negedge clk);
    checkCount++;
    if (!ok || state !== 3'd6)
      $display("[TB] FAIL reach_rd_wait: reached=%0d state=%0d, required 1/6", ok, state);
    else passCount++;
    reset_n = 1'b0;
    @(negedge clk);
    checkCount++;
    if (state !== 3'd0 || uart_cts !== 1'b1 || cmd_count !== 16'd0 || tx_write !== 1'b0 || data_size !== 8'd0)
      $display("[TB] FAIL mid_reset: state=%0d cts=%b count=%0d txw=%b size=%0d, required 0/1/0/0/0",
               state, uart_cts, cmd_count, tx_write, data_size);
    else passCount++;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkCount++;
    if (txCount - txBefore != 1 || expTxQ.size() != 0)
      $display("[TB] FAIL mid_reset_tx: tx=%0d pending=%0d, required 1/0", txCount - txBefore, expTxQ.size());
    else passCount++;
    expWrQ.push_back('{addr: 7'h01, data: 8'h77});
    startCmd();
    applyStimulus(8'h81);
    applyStimulus(8'h01);
    applyStimulus(8'h77);
    @(negedge clk);
    checkCount++;
    if (state !== 3'd0 || cmd_count !== 16'd1 || expWrQ.size() != 0)
      $display("[TB] FAIL after_reset_cmd: state=%0d count=%0d pending=%0d, required 0/1/0",
               state, cmd_count, expWrQ.size());
    else passCount++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_zero_wrap();
    test_timeout();
    test_rx_error();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/monitor_cmd_ctrl.md
Name: monitor_cmd_ctrl

Overview:
Command sequencer for the monitor UART link. It sits between the uart_rx/uart_tx byte datapath and a byte-wide monitor register file.
- Write commands: receives a command byte and a size byte, then streams payload bytes into consecutive registers.
- Read commands: fetches consecutive registers and drives them out through the transmitter.
- Flow control: handles the RTS/CTS handshake, an inter-event timeout and error reporting.
- Replaces the ad-hoc command state machine in the monitor top level.

Parameters:
ADDR_W, 7, register-file address width (equals command id width).
TIMEOUT_CYCLES, 500000, clk cycles without progress before abort (10 ms at 50 MHz).
CNT_W, 16, width of completed-command counter.

Ports:
clk  in  1  50 MHz system clock
reset_n  in  1  synchronous reset, active-low
rx_valid  in  1  one-cycle pulse, rx_byte valid
rx_byte  in  8  received byte
rx_busy  in  1  receiver mid-frame
rx_error  in  1  one-cycle pulse, parity/framing error
tx_write  out  1  one-cycle pulse, start transmit of tx_byte
tx_byte  out  8  byte to transmit
tx_busy  in  1  transmitter mid-frame
tx_done  in  1  one-cycle pulse, frame finished
uart_rts  in  1  controller request to send, active-low
uart_cts  out  1  clear to send, active-low
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  register write data
reg_we  out  1  write strobe, one cycle
reg_re  out  1  read strobe, one cycle
reg_rdata  in  8  read data, valid the cycle after reg_re
state  out  3  current FSM state
cmd_rw  out  1  latched command bit 7 (1 = write)
cmd_id  out  ADDR_W  latched command bits 6:0 (base address)
data_size  out  8  latched byte count
err_timeout  out  1  one-cycle pulse on timeout abort
err_rx  out  1  one-cycle pulse on rx_error abort
cmd_count  out  CNT_W  completed commands, wraps

Behaviour:
- Reset (reset_n=0 at posedge clk): state=IDLE, uart_cts=1, tx_write=0, tx_byte=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, cmd_rw=0, cmd_id=0, data_size=0, err_timeout=0, err_rx=0, cmd_count=0, index=0, timer=0.
- Reset mid-operation aborts immediately: no further strobes, no cmd_count increment.
- All outputs are registered.
- State encoding: IDLE=0, CMD=1, SIZE=2, WR_DATA=3, RD_FETCH=4, RD_SEND=5, RD_WAIT=6, DONE=7.
- IDLE:
  - uart_cts=1.
  - If uart_rts=0 and rx_busy=0: go to CMD and set uart_cts=0 on the same edge.
  - rx_valid in IDLE is ignored.
- CMD: on rx_valid, latch cmd_rw=rx_byte[7] and cmd_id=rx_byte[6:0], then go to SIZE.
- SIZE: on rx_valid, latch data_size and clear index.
  - data_size=0: go to DONE.
  - cmd_rw=1: go to WR_DATA.
  - cmd_rw=0: go to RD_FETCH and set uart_cts=1.
- WR_DATA: on each rx_valid, next cycle reg_we=1, reg_addr=cmd_id+index (mod 2^ADDR_W), reg_wdata=rx_byte, index++.
  - After the write with index=data_size-1: go to DONE and set uart_cts=1.
- RD_FETCH:
  - Wait until tx_busy=0, then pulse reg_re with reg_addr=cmd_id+index (mod 2^ADDR_W) and go to RD_SEND.
  - uart_cts=1 throughout reads.
- RD_SEND: capture reg_rdata into tx_byte, pulse tx_write for one cycle, go to RD_WAIT.
- RD_WAIT: on tx_done, index++. If the new index equals data_size go to DONE, else go to RD_FETCH.
- DONE: one cycle; cmd_count++ (wraps), uart_cts=1, go to IDLE.
  - A new command needs RTS low again in IDLE; an RTS held low starts the next command the cycle after DONE.
- uart_cts=0 only in CMD, SIZE and WR_DATA.
- Timer:
  - Counts in every state except IDLE and DONE.
  - Cleared on state change, rx_valid and tx_done.
  - Reaching TIMEOUT_CYCLES-1: err_timeout pulse, uart_cts=1, go to IDLE.
  - If rx_valid or tx_done arrives in the same cycle, that event wins and no timeout fires.
- rx_error in CMD, SIZE or WR_DATA: err_rx pulse, uart_cts=1, go to IDLE. Bytes already written are not rolled back.
  - rx_error wins over a simultaneous rx_valid.
  - rx_error in other states is ignored.
- Address wrap: cmd_id=0x7F with 2 bytes accesses 0x7F, then 0x00.
- data_size=255 is the maximum; index is 8 bits.
- rx_valid during read states is ignored.
- reg_we and reg_re are never asserted in the same cycle.

Test Plan:
- Write: RTS low, send 0x85, 0x03, then 0xAA 0xBB 0xCC -> cts drops in CMD; writes 0xAA@0x05, 0xBB@0x06, 0xCC@0x07, one reg_we each; cts=1 after the third write; cmd_count=1.
- Read: regfile[0x10..0x11]=0x12,0x34; send 0x10, 0x02 -> cts=1 after SIZE; two tx_write pulses with tx_byte 0x12 then 0x34, the second only after the first tx_done; back to IDLE.
- Zero size plus wrap:
  - 0x80, 0x00 -> no reg_we, DONE, cmd_count increments.
  - 0xFF, 0x02, 0x11, 0x22 -> writes 0x7F then 0x00.
- Timeout: send 0x85 then silence for TIMEOUT_CYCLES -> one err_timeout pulse, state=IDLE, uart_cts=1, cmd_count unchanged.
  - A rx_valid arriving on the final count cycle prevents the timeout.
- RX error: 0x85, 0x04, 0x01, then rx_error pulse -> err_rx pulse, exactly one reg_we (0x01@0x05), IDLE.
- Reset mid-read: assert reset_n=0 during RD_WAIT -> next edge shows all reset values, no further tx_write; the next command completes normally.
